// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: shared constants, queue entry and FSM encoding for the branch resolver.
package branch_resolver_pkg;
    localparam logic [6:0]  BRANCH_OPCODE = 7'b1100011;
    localparam int          PC_W          = 32;
    localparam logic [31:0] INSN_STEP     = 32'd4;

    typedef struct packed {
        logic            taken;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
    } entry_t;

    typedef enum logic {RUN, DRAIN} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/branch_pred_fifo.sv
// branch_pred_fifo: circular FIFO with push/pop/clear; clear wins over both.
module branch_pred_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: matches fetch-time predictions against execute outcomes,
// issues flush/redirect on mispredict, feeds the predictor and keeps stats.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DRAIN_CYC = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pred_valid,
    input  logic                   pred_taken,
    input  logic [31:0]            pred_pc,
    input  logic [31:0]            pred_target,
    output logic                   pred_ready,
    input  logic                   res_valid,
    input  logic                   res_taken,
    input  logic [31:0]            res_target,
    output logic                   flush,
    output logic [31:0]            redirect_pc,
    output logic                   update_valid,
    output logic                   update_truth,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [15:0]            branch_count,
    output logic [15:0]            mispredict_count,
    output logic                   protocol_err
);
    localparam int CW = $clog2(DRAIN_CYC + 2);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    entry_t        head;
    logic [$bits(entry_t)-1:0] head_bits;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          mispredict;
    logic [31:0]   redirect_calc;

    assign head          = entry_t'(head_bits);
    assign pop           = res_valid && !empty;
    assign mispredict    = pop && ((head.taken != res_taken) ||
                                   (head.taken && res_taken && head.target != res_target));
    assign redirect_calc = res_taken ? res_target : head.pc + INSN_STEP;
    assign push          = pred_valid && pred_ready && !mispredict;

    // Younger entries are wrong-path on a mispredict, so the queue is cleared
    branch_pred_fifo #(.WIDTH($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (mispredict),
        .din   ({pred_taken, pred_pc, pred_target}),
        .dout  (head_bits),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        pred_ready = reset && (state == RUN) && !full;
        if (state == RUN) begin
            if (mispredict && DRAIN_CYC != 0) begin
                state_d = DRAIN;
                cnt_d   = CW'(DRAIN_CYC);
            end
        end else if (cnt <= CW'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush            <= 1'b0;
            redirect_pc      <= '0;
            update_valid     <= 1'b0;
            update_truth     <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
            protocol_err     <= 1'b0;
        end else begin
            flush        <= mispredict;
            redirect_pc  <= mispredict ? redirect_calc : '0;
            update_valid <= pop;
            update_truth <= pop && res_taken;
            if (pop)               branch_count     <= sat_inc(branch_count);
            if (mispredict)        mispredict_count <= sat_inc(mispredict_count);
            if (res_valid && empty) protocol_err    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed stimulus, queue-based reference model checked every cycle.
module tb_branch_resolver;
    localparam int DEPTH     = 4;
    localparam int DRAIN_CYC = 2;

    logic        clk = 0;
    logic        reset = 0;
    logic        pred_valid = 0, pred_taken = 0, res_valid = 0, res_taken = 0;
    logic [31:0] pred_pc = 0, pred_target = 0, res_target = 0;
    logic        pred_ready, flush, update_valid, update_truth, protocol_err;
    logic [31:0] redirect_pc;
    logic [2:0]  occupancy;
    logic [15:0] branch_count, mispredict_count;

    int total = 0;
    int bad   = 0;

    branch_resolver #(.DEPTH(DEPTH), .DRAIN_CYC(DRAIN_CYC)) dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
        .pred_target(pred_target), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .flush(flush), .redirect_pc(redirect_pc),
        .update_valid(update_valid), .update_truth(update_truth),
        .occupancy(occupancy), .branch_count(branch_count),
        .mispredict_count(mispredict_count), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of outstanding predictions plus a drain countdown
    typedef struct {logic taken; logic [31:0] pc; logic [31:0] tgt;} ent_t;
    ent_t        q[$];
    ent_t        m_h;
    int          drain_left = 0;
    bit          m_rdy, m_mis;
    logic        e_flush = 0, e_uv = 0, e_ut = 0, e_perr = 0;
    logic [31:0] e_rpc = 0;
    logic [15:0] e_bc = 0, e_mc = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            drain_left = 0;
            {e_flush, e_uv, e_ut, e_perr} = '0;
            e_rpc = 0; e_bc = 0; e_mc = 0;
        end else begin
            m_rdy = (drain_left == 0) && (q.size() < DEPTH);
            m_mis = 0;
            e_flush = 0; e_uv = 0; e_ut = 0; e_rpc = 0;
            if (drain_left > 0) drain_left--;
            if (res_valid && q.size() == 0) e_perr = 1;
            else if (res_valid) begin
                m_h   = q.pop_front();
                m_mis = (m_h.taken != res_taken) || (res_taken && m_h.tgt != res_target);
                e_uv  = 1;
                e_ut  = res_taken;
                if (e_bc != 16'hFFFF) e_bc++;
                if (m_mis) begin
                    if (e_mc != 16'hFFFF) e_mc++;
                    e_flush = 1;
                    e_rpc = res_taken ? res_target : m_h.pc + 32'd4;
                    q.delete();
                    drain_left = DRAIN_CYC;
                end
            end
            if (m_rdy && pred_valid && !m_mis) q.push_back('{pred_taken, pred_pc, pred_target});
        end
    end

    always @(negedge clk) begin
        chk("ready", pred_ready, reset && drain_left == 0 && q.size() < DEPTH);
        chk("occupancy", occupancy, q.size());
        chk("flush", flush, e_flush);
        if (e_flush) chk("redirect_pc", redirect_pc, e_rpc);
        chk("update_valid", update_valid, e_uv);
        if (e_uv) chk("update_truth", update_truth, e_ut);
        chk("branch_count", branch_count, e_bc);
        chk("mispredict_count", mispredict_count, e_mc);
        chk("protocol_err", protocol_err, e_perr);
    end

    // Drive one cycle of inputs starting just after a negedge; returns just after the next negedge
    task automatic cyc(input bit pv, input bit pt, input logic [31:0] pp, input logic [31:0] pg,
                       input bit rv, input bit rt, input logic [31:0] rg);
        pred_valid = pv; pred_taken = pt; pred_pc = pp; pred_target = pg;
        res_valid = rv; res_taken = rt; res_target = rg;
        @(negedge clk); #1;
        pred_valid = 0; res_valid = 0;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("lit_ready_in_reset", pred_ready, 0);
        chk("lit_flush_in_reset", flush, 0);
        reset = 1;
        #1;
        chk("lit_ready_after_reset", pred_ready, 1);

        // correct taken prediction
        cyc(1, 1, 32'h100, 32'h80, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'h80);
        chk("lit_t1_uv", update_valid, 1);
        chk("lit_t1_truth", update_truth, 1);
        chk("lit_t1_flush", flush, 0);
        chk("lit_t1_bc", branch_count, 1);
        idle();

        // predicted not-taken, actually taken
        cyc(1, 0, 32'h200, 32'h0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'h240);
        chk("lit_t2_flush", flush, 1);
        chk("lit_t2_rpc", redirect_pc, 32'h240);
        chk("lit_t2_mc", mispredict_count, 1);
        chk("lit_t2_ready0", pred_ready, 0);
        idle();
        chk("lit_t2_ready1", pred_ready, 0);
        idle();
        chk("lit_t2_ready2", pred_ready, 1);

        // mispredict the oldest of three; younger two are discarded
        cyc(1, 1, 32'h300, 32'h380, 0, 0, 0);
        cyc(1, 0, 32'h310, 32'h0, 0, 0, 0);
        cyc(1, 1, 32'h320, 32'h400, 0, 0, 0);
        chk("lit_t3_occ3", occupancy, 3);
        cyc(0, 0, 0, 0, 1, 0, 32'h0);
        chk("lit_t3_rpc", redirect_pc, 32'h304);
        chk("lit_t3_occ0", occupancy, 0);
        chk("lit_t3_flush", flush, 1);
        idle();
        idle();

        // fill, refuse fifth, simultaneous push/pop, drain
        for (int i = 0; i < 4; i++) cyc(1, 0, 32'h400 + 32'(i * 16), 32'h0, 0, 0, 0);
        chk("lit_t4_full_ready", pred_ready, 0);
        chk("lit_t4_full_occ", occupancy, 4);
        cyc(1, 0, 32'h5F0, 32'h0, 1, 0, 32'h0);
        chk("lit_t4_occ_after_pop", occupancy, 3);
        chk("lit_t4_ready_after_pop", pred_ready, 1);
        cyc(1, 0, 32'h600, 32'h0, 1, 0, 32'h0);
        chk("lit_t4_occ_pushpop", occupancy, 3);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, 32'h0);
        chk("lit_t4_occ_empty", occupancy, 0);
        chk("lit_t4_bc", branch_count, 8);

        // resolve with nothing outstanding
        cyc(0, 0, 0, 0, 1, 1, 32'h0);
        chk("lit_t5_perr", protocol_err, 1);
        chk("lit_t5_uv", update_valid, 0);
        chk("lit_t5_flush", flush, 0);
        idle();
        chk("lit_t5_perr_sticky", protocol_err, 1);

        // same direction, wrong target; then reset mid-drain
        cyc(1, 1, 32'h4F0, 32'h500, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'h504);
        chk("lit_t6_flush", flush, 1);
        chk("lit_t6_rpc", redirect_pc, 32'h504);
        chk("lit_t6_mc", mispredict_count, 3);
        reset = 0;
        #1;
        chk("lit_t6_rst_flush", flush, 0);
        chk("lit_t6_rst_rpc", redirect_pc, 0);
        chk("lit_t6_rst_bc", branch_count, 0);
        chk("lit_t6_rst_perr", protocol_err, 0);
        chk("lit_t6_rst_ready", pred_ready, 0);
        idle();
        reset = 1;
        #1;
        chk("lit_t6_ready_release", pred_ready, 1);
        idle();
        chk("lit_t6_no_flush", flush, 0);
        chk("lit_t6_ready_run", pred_ready, 1);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
